// File: rtl/ysyx_22041071_wb_buf.sv
// Write-back buffer: DEPTH-entry FIFO between MEM and regfile/commit.
// Optional retire counter enabled by YSYX_22041071_WB_RETIRE_CNT_EN.
module ysyx_22041071_wb_buf #(
  parameter int ADDR_W = 64,
  parameter int INS_W  = 32,
  parameter int DATA_W = 64,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [INS_W-1:0]  ins_in,
  input  logic              wen_in,
  input  logic [REG_AW-1:0] rd_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [INS_W-1:0]  ins_out,
  output logic              rf_wen,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data
`ifdef YSYX_22041071_WB_RETIRE_CNT_EN
  ,
  output logic [63:0]       retire_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PONE = 1;
  localparam logic [PW-1:0] IONE = 1;

  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [INS_W-1:0]  ins_q  [DEPTH];
  logic              wen_q  [DEPTH];
  logic [REG_AW-1:0] rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [PW:0]   wptr, rptr;
  logic [PW-1:0] hidx, nidx;
  logic          empty, full, push, pop;

  assign hidx  = rptr[PW-1:0];
  assign nidx  = wptr[PW-1:0] - IONE;
  assign empty = (wptr == rptr);
  assign full  = (wptr[PW] != rptr[PW]) &&
                 (wptr[PW-1:0] == rptr[PW-1:0]);

  assign ready_in  = !full;
  assign valid_out = !empty && !flush;
  assign push      = valid_in && ready_in && !flush;
  assign pop       = valid_out && ready_out;

  always_comb begin
    pc_out    = '0;
    ins_out   = '0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    rf_wen    = 1'b0;
    fwd_valid = 1'b0;
    fwd_rd    = '0;
    fwd_data  = '0;
    if (!empty) begin
      pc_out    = pc_q[hidx];
      ins_out   = ins_q[hidx];
      rf_waddr  = rd_q[hidx];
      rf_wdata  = data_q[hidx];
      rf_wen    = pop && wen_q[hidx] && (rd_q[hidx] != '0);
      fwd_rd    = rd_q[nidx];
      fwd_data  = data_q[nidx];
      fwd_valid = !flush && wen_q[nidx] && (rd_q[nidx] != '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PONE;
      if (pop)  rptr <= rptr + PONE;
    end
  end

  // Payload needs no reset: it is only observed while non-empty.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wptr[PW-1:0]]   <= pc_in;
      ins_q[wptr[PW-1:0]]  <= ins_in;
      wen_q[wptr[PW-1:0]]  <= wen_in;
      rd_q[wptr[PW-1:0]]   <= rd_in;
      data_q[wptr[PW-1:0]] <= data_in;
    end
  end

`ifdef YSYX_22041071_WB_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   retire_cnt <= '0;
    else if (pop) retire_cnt <= retire_cnt + 64'd1;
  end
`endif

endmodule

// File: tb/tb_ysyx_22041071_wb_buf.sv
// Scoreboard bench for ysyx_22041071_wb_buf.
// Checks retire_cnt when YSYX_22041071_WB_RETIRE_CNT_EN is defined.
module tb_ysyx_22041071_wb_buf;
  localparam int DEPTH = 2;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
    logic        wen;
    logic [4:0]  rd;
    logic [63:0] data;
  } ent_t;

  logic        clk, reset, flush, valid_in, ready_in;
  logic [63:0] pc_in, data_in, pc_out, rf_wdata, fwd_data;
  logic [31:0] ins_in, ins_out;
  logic        wen_in, valid_out, ready_out, rf_wen, fwd_valid;
  logic [4:0]  rd_in, rf_waddr, fwd_rd;
`ifdef YSYX_22041071_WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt;
`endif

  ysyx_22041071_wb_buf #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .valid_in(valid_in), .ready_in(ready_in),
    .pc_in(pc_in), .ins_in(ins_in), .wen_in(wen_in),
    .rd_in(rd_in), .data_in(data_in),
    .valid_out(valid_out), .ready_out(ready_out),
    .pc_out(pc_out), .ins_out(ins_out),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`ifdef YSYX_22041071_WB_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ent_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          commits = 0;
  logic        chk_en = 1'b0;
  logic [63:0] exp_cnt = '0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the buffered model contents
  initial begin
    ent_t h, n;
    logic exp_vo;
    forever begin
      @(negedge clk);
      #2;
      if (chk_en) begin
        exp_vo = (sb.size() > 0) && !flush;
        chk("ready_in", ready_in, sb.size() < DEPTH);
        chk("valid_out", valid_out, exp_vo);
`ifdef YSYX_22041071_WB_RETIRE_CNT_EN
        chk("retire_cnt", retire_cnt, exp_cnt);
`endif
        if (sb.size() > 0) begin
          h = sb[0];
          n = sb[sb.size()-1];
          chk("pc_out", pc_out, h.pc);
          chk("ins_out", ins_out, 64'(h.ins));
          chk("rf_waddr", rf_waddr, 64'(h.rd));
          chk("rf_wdata", rf_wdata, h.data);
          chk("rf_wen", rf_wen,
              exp_vo && ready_out && h.wen && h.rd != 0);
          chk("fwd_valid", fwd_valid, !flush && n.wen && n.rd != 0);
          chk("fwd_rd", fwd_rd, 64'(n.rd));
          chk("fwd_data", fwd_data, n.data);
        end else begin
          chk("pc_out_empty", pc_out, 64'd0);
          chk("rf_wen_empty", rf_wen, 1'b0);
          chk("fwd_valid_empty", fwd_valid, 1'b0);
        end
        if (exp_vo && ready_out) begin
          void'(sb.pop_front());
          exp_cnt++;
          commits++;
        end
      end
    end
  end

  function automatic ent_t rnd_ent();
    ent_t e;
    e.pc   = {$urandom, $urandom};
    e.ins  = $urandom;
    e.wen  = ($urandom_range(0, 4) != 0);
    e.rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    e.data = {$urandom, $urandom};
    return e;
  endfunction

  // One cycle of stimulus; returns whether the model accepted the push
  task automatic step(input logic v, input logic r, input logic f,
                      input ent_t e, output logic acc);
    @(negedge clk);
    valid_in  = v;
    ready_out = r;
    flush     = f;
    pc_in     = e.pc;
    ins_in    = e.ins;
    wen_in    = e.wen;
    rd_in     = e.rd;
    data_in   = e.data;
    #1;
    acc = v && (sb.size() < DEPTH) && !f;
    #3;
    if (f) sb.delete();
    else if (acc) sb.push_back(e);
  endtask

  task automatic push_hold(input ent_t e, input logic r);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) step(1'b1, r, 1'b0, e, acc);
    if (!acc) begin
      fails++;
      $display("FAIL push_hold: accepted %0d required 1", acc);
    end
  endtask

  task automatic idle(input logic r, input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, r, 1'b0, rnd_ent(), acc);
  endtask

  initial begin
    ent_t e;
    logic acc;
    reset = 1'b0;
    flush = 1'b0;
    valid_in = 1'b0;
    ready_out = 1'b0;
    pc_in = '0; ins_in = '0; wen_in = 1'b0; rd_in = '0; data_in = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_pc_out", pc_out, 64'd0);
    chk("rst_fwd_valid", fwd_valid, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    chk_en = 1'b1;

    // single push, commit next cycle
    e = '{pc: 64'h8000_0000, ins: 32'h0000_0013, wen: 1'b1,
          rd: 5'd5, data: 64'h1234};
    step(1'b1, 1'b1, 1'b0, e, acc);
    idle(1'b1, 2);

    // fill with backpressure, third held off, then drain
    push_hold(rnd_ent(), 1'b0);
    push_hold(rnd_ent(), 1'b0);
    step(1'b1, 1'b0, 1'b0, rnd_ent(), acc);
    chk("third_held", acc, 1'b0);
    push_hold(rnd_ent(), 1'b1);
    idle(1'b1, 3);

    // commit to x0
    e = '{pc: 64'h8000_0010, ins: 32'h0000_0093, wen: 1'b1,
          rd: 5'd0, data: 64'hdead};
    step(1'b1, 1'b1, 1'b0, e, acc);
    idle(1'b1, 2);

    // streaming
    for (int i = 0; i < 10; i++) begin
      e = rnd_ent();
      e.pc = 64'h8000_1000 + 64'(i * 4);
      step(1'b1, 1'b1, 1'b0, e, acc);
    end
    idle(1'b1, 2);

    // flush with two buffered and a simultaneous push
    push_hold(rnd_ent(), 1'b0);
    push_hold(rnd_ent(), 1'b0);
    step(1'b1, 1'b1, 1'b1, rnd_ent(), acc);
    idle(1'b1, 2);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 24) == 0, rnd_ent(), acc);
    idle(1'b1, 4);

    // asynchronous reset mid-cycle with two buffered
    push_hold(rnd_ent(), 1'b0);
    push_hold(rnd_ent(), 1'b0);
    @(negedge clk);
    valid_in = 1'b0;
    #3;
    reset = 1'b0;
    chk_en = 1'b0;
    #1;
    chk("arst_valid_out", valid_out, 1'b0);
    chk("arst_rf_wen", rf_wen, 1'b0);
    chk("arst_fwd_valid", fwd_valid, 1'b0);
    sb.delete();
    exp_cnt = '0;
    @(negedge clk);
    reset = 1'b1;
    chk_en = 1'b1;
    idle(1'b1, 2);

    chk("commits_seen", 64'(commits > 20), 64'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: time %0t limit 200000", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ysyx_22041071_wb_buf.md
Name: ysyx_22041071_wb_buf

Overview:
- Parametrised write-back stage for the ysyx_22041071 5-stage core; sits between MEM and the register file / difftest commit.
- Replaces the pass-through WB with a registered DEPTH-entry FIFO and full valid/ready backpressure on both sides.
- Generates the register-file write strobe, with x0 suppression, at commit time.
- Exposes the newest buffered write for EX-stage forwarding, and supports a synchronous pipeline flush.

Parameters:
- ADDR_W, 64: PC width.
- INS_W, 32: instruction width.
- DATA_W, 64: write-back data width.
- REG_AW, 5: register index width.
- DEPTH, 2: buffer entries; power of two, minimum 2.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous flush; drops all buffered entries.
- valid_in  input  1  MEM entry valid.
- ready_in  output  1  WB can accept an entry.
- pc_in  input  ADDR_W  PC of the entry.
- ins_in  input  INS_W  instruction of the entry.
- wen_in  input  1  entry writes rd.
- rd_in  input  REG_AW  destination register.
- data_in  input  DATA_W  write-back data.
- valid_out  output  1  head entry ready to commit.
- ready_out  input  1  commit consumer (difftest/regfile) accepts.
- pc_out  output  ADDR_W  head PC.
- ins_out  output  INS_W  head instruction.
- rf_wen  output  1  register-file write strobe.
- rf_waddr  output  REG_AW  register-file write address.
- rf_wdata  output  DATA_W  register-file write data.
- fwd_valid  output  1  newest buffered entry writes a non-zero rd.
- fwd_rd  output  REG_AW  newest entry rd.
- fwd_data  output  DATA_W  newest entry data.

Behaviour:
- Storage:
  - Circular FIFO with DEPTH entries, read/write pointers of log2(DEPTH) bits plus a wrap bit.
  - full: pointers equal, wrap bits differ. empty: pointers and wrap bits equal.
  - Pointers wrap from DEPTH-1 to 0.
- Reset (reset=0, asynchronous):
  - Pointers cleared, so the buffer is empty.
  - valid_out=0, rf_wen=0, fwd_valid=0; all data outputs are 0.
  - ready_in=1 once reset deasserts.
  - Reset during any operation discards all entries, with no write that cycle.
- Handshakes:
  - Push when valid_in && ready_in. ready_in = !full; it is purely a function of registered state, with no combinational path from ready_out.
  - Pop when valid_out && ready_out. valid_out = !empty.
  - Push and pop in the same cycle are both allowed when neither full nor empty; occupancy is unchanged.
  - When full, ready_in=0 even if a pop occurs that cycle.
- Latency:
  - An entry pushed at edge t is visible on the head outputs after edge t; minimum latency is 1 cycle.
  - No combinational flow-through.
  - Order is strictly FIFO.
- Head outputs: pc_out, ins_out, rf_waddr and rf_wdata always reflect the head entry. They are 0 when the buffer is empty.
- Register-file write:
  - rf_wen = pop && head.wen && (head.rd != 0).
  - A write to x0 still commits (the pop happens) but rf_wen=0.
- Forwarding:
  - fwd_* reflect the most recently pushed entry still buffered.
  - fwd_valid = !empty && newest.wen && newest.rd != 0.
  - If that entry pops in the current cycle it is still reported that cycle.
- Flush:
  - At the next edge, pointers reset to empty and any push that cycle is dropped.
  - While flush=1: rf_wen=0, valid_out=0 and fwd_valid=0 (gated combinationally).
  - flush has priority over push and pop.
  - reset has priority over flush.
- Widths: all fields are stored at full parameter width; no truncation or extension.

Optional Feature:
- Macro: YSYX_22041071_WB_RETIRE_CNT_EN.
- When defined:
  - Adds output retire_cnt, 64 bits.
  - Increments by 1 on every pop that is not suppressed by flush, including x0 writes and wen=0 entries.
  - Cleared by reset, not by flush; wraps modulo 2^64.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then a single push (pc=0x80000000, wen=1, rd=5, data=0x1234) with ready_out=1 -> valid_out=1 the next cycle with rf_wen=1, rf_waddr=5, rf_wdata=0x1234; empty afterwards.
- ready_out=0 and push 2 entries (DEPTH=2) -> ready_in=0 after the second; third valid_in is held off. ready_out=1 -> entries pop in order on consecutive cycles, and ready_in returns to 1 after the first pop.
- Push with rd=0, wen=1, data=0xdead -> entry commits (valid_out && ready_out) with rf_wen=0; retire_cnt (if enabled) increments by 1.
- Continuous push and pop with ready_out=1 for 10 cycles -> one commit per cycle at 1-cycle latency; pointers wrap correctly; output PC sequence matches input.
- Two entries buffered, then flush=1 with a simultaneous push -> next cycle empty, no rf_wen during or after the flush, and the pushed entry is lost.
- Two entries buffered, reset asserted asynchronously mid-cycle -> valid_out, rf_wen and fwd_valid drop immediately; after release, ready_in=1, and retire_cnt=0 if enabled.
